// File: rtl/simplebus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : simplebus_arbiter
// Brief  : Round-robin arbiter sharing one Simplebus slave between N masters.
// Rev    : 1.0 - initial release
// ============================================================================
module simplebus_arbiter #(
  parameter int N_MASTERS    = 2,
  parameter int READ_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [32*N_MASTERS-1:0] m_sb_address,
  input  logic [N_MASTERS-1:0]    m_sb_read_strobe,
  input  logic [N_MASTERS-1:0]    m_sb_write_strobe,
  input  logic [32*N_MASTERS-1:0] m_sb_write_data,
  output logic [32*N_MASTERS-1:0] m_sb_read_data,
  output logic [N_MASTERS-1:0]    m_sb_read_valid,
  output logic [N_MASTERS-1:0]    m_sb_ready,
  output logic [31:0]             s_sb_address,
  output logic                    s_sb_read_strobe,
  output logic                    s_sb_write_strobe,
  output logic [31:0]             s_sb_write_data,
  input  logic [31:0]             s_sb_read_data,
  input  logic                    s_sb_read_valid,
  input  logic                    s_sb_ready,
  output logic                    read_timeout
);

  localparam int c_IDX_W = $clog2(N_MASTERS);
  localparam int c_CNT_W = $clog2(READ_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(READ_TIMEOUT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_MASTERS - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_W_WAIT = 2'd1;
  localparam logic [1:0] c_R_WAIT = 2'd2;

  logic [1:0]              r_state;
  logic [c_IDX_W-1:0]      r_last_grant;
  logic [c_CNT_W-1:0]      r_cnt;
  logic                    r_first;
  logic                    r_live;
  logic [N_MASTERS-1:0]    r_pending;
  logic [31:0]             r_buf_addr  [N_MASTERS];
  logic [31:0]             r_buf_data  [N_MASTERS];
  logic                    r_buf_write [N_MASTERS];
  logic [32*N_MASTERS-1:0] r_rdata;
  logic [N_MASTERS-1:0]    r_rvalid;
  logic [31:0]             r_s_addr;
  logic [31:0]             r_s_wdata;
  logic                    r_s_rstb;
  logic                    r_s_wstb;
  logic                    r_timeout;

  logic [N_MASTERS-1:0]    w_capture;
  logic [N_MASTERS-1:0]    w_done_mask;
  logic                    w_found;
  logic                    w_done;
  logic                    w_timeout_hit;
  logic [c_IDX_W-1:0]      w_winner;
  logic [c_IDX_W-1:0]      w_sel;

  // Ready stays low until the first cycle after reset releases.
  assign m_sb_ready = {N_MASTERS{r_live}} & ~r_pending;
  assign w_capture  = m_sb_ready & (m_sb_write_strobe | m_sb_read_strobe);

  // First pending master after the last grant, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_sel    = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_sel = c_IDX_W'((int'(r_last_grant) + k) % N_MASTERS);
      if (!w_found && r_pending[w_sel]) begin
        w_found  = 1'b1;
        w_winner = w_sel;
      end
    end
  end

  always_comb begin
    w_done        = 1'b0;
    w_timeout_hit = 1'b0;
    w_done_mask   = '0;
    case (r_state)
      c_W_WAIT: w_done = !r_first && s_sb_ready;
      c_R_WAIT: begin
        w_timeout_hit = !s_sb_read_valid && (r_cnt == c_CNT_LAST);
        w_done        = s_sb_read_valid || w_timeout_hit;
      end
      default: ;
    endcase
    if (w_done) w_done_mask[r_last_grant] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        r_buf_addr[i]  <= '0;
        r_buf_data[i]  <= '0;
        r_buf_write[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (w_capture[i]) begin
          r_buf_addr[i]  <= m_sb_address[32*i +: 32];
          r_buf_data[i]  <= m_sb_write_data[32*i +: 32];
          r_buf_write[i] <= m_sb_write_strobe[i];
        end
      end
    end
  end

  // A completion and a new capture never hit the same master on one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_live    <= 1'b0;
      r_pending <= '0;
    end else begin
      r_live    <= 1'b1;
      r_pending <= (r_pending & ~w_done_mask) | w_capture;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_last_grant <= c_IDX_LAST;
      r_cnt        <= '0;
      r_first      <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= '0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_rstb     <= 1'b0;
      r_s_wstb     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_s_rstb  <= 1'b0;
      r_s_wstb  <= 1'b0;
      r_rvalid  <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_found && s_sb_ready) begin
            r_s_addr     <= r_buf_addr[w_winner];
            r_s_wdata    <= r_buf_data[w_winner];
            r_last_grant <= w_winner;
            r_cnt        <= '0;
            r_first      <= 1'b1;
            if (r_buf_write[w_winner]) begin
              r_s_wstb <= 1'b1;
              r_state  <= c_W_WAIT;
            end else begin
              r_s_rstb <= 1'b1;
              r_state  <= c_R_WAIT;
            end
          end
        end
        c_W_WAIT: begin
          r_first <= 1'b0;
          if (w_done) r_state <= c_IDLE;
        end
        c_R_WAIT: begin
          if (w_done) begin
            r_rdata[32*r_last_grant +: 32] <= w_timeout_hit ? 32'd0 : s_sb_read_data;
            r_rvalid[r_last_grant]         <= 1'b1;
            r_timeout                      <= w_timeout_hit;
            r_state                        <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign m_sb_read_data    = r_rdata;
  assign m_sb_read_valid   = r_rvalid;
  assign s_sb_address      = r_s_addr;
  assign s_sb_write_data   = r_s_wdata;
  assign s_sb_read_strobe  = r_s_rstb;
  assign s_sb_write_strobe = r_s_wstb;
  assign read_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_simplebus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_simplebus_arbiter
// Brief  : Directed bench for simplebus_arbiter with a cycle-level behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_simplebus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [32*N-1:0] m_sb_address      = '0;
  logic [N-1:0]    m_sb_read_strobe  = '0;
  logic [N-1:0]    m_sb_write_strobe = '0;
  logic [32*N-1:0] m_sb_write_data   = '0;
  logic [32*N-1:0] m_sb_read_data;
  logic [N-1:0]    m_sb_read_valid;
  logic [N-1:0]    m_sb_ready;
  logic [31:0]     s_sb_address;
  logic            s_sb_read_strobe;
  logic            s_sb_write_strobe;
  logic [31:0]     s_sb_write_data;
  logic [31:0]     s_sb_read_data  = '0;
  logic            s_sb_read_valid = 1'b0;
  logic            s_sb_ready      = 1'b1;
  logic            read_timeout;

  always #5 clock = ~clock;

  simplebus_arbiter #(.N_MASTERS(N), .READ_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m_sb_address(m_sb_address), .m_sb_read_strobe(m_sb_read_strobe),
    .m_sb_write_strobe(m_sb_write_strobe), .m_sb_write_data(m_sb_write_data),
    .m_sb_read_data(m_sb_read_data), .m_sb_read_valid(m_sb_read_valid),
    .m_sb_ready(m_sb_ready), .s_sb_address(s_sb_address),
    .s_sb_read_strobe(s_sb_read_strobe), .s_sb_write_strobe(s_sb_write_strobe),
    .s_sb_write_data(s_sb_write_data), .s_sb_read_data(s_sb_read_data),
    .s_sb_read_valid(s_sb_read_valid), .s_sb_ready(s_sb_ready),
    .read_timeout(read_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] alog [$];   // slave addresses in the order the DUT issued them

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] mp_pend;
  logic [31:0]  mp_addr [N];
  logic [31:0]  mp_data [N];
  logic         mp_wr   [N];
  int           m_last, m_inf, m_age;
  logic         m_inf_wr, m_live;
  logic [31:0]  e_rdata [N];
  logic [31:0]  e_saddr, e_swd;
  // Inputs as they stood just before the next rising edge.
  logic            sn_rst = 1'b1;
  logic [N-1:0]    sn_rs = '0, sn_ws = '0, sn_rdy = '0;
  logic [32*N-1:0] sn_addr = '0, sn_wd = '0;
  logic            sn_srdy = 1'b0, sn_rv = 1'b0;
  logic [31:0]     sn_rdat = '0;

  always @(negedge clock) begin : p_cmp
    logic [N-1:0]    e_mrv, cap, e_rdy;
    logic            e_ws, e_rs, e_to;
    logic [32*N-1:0] e_flat;
    int              w;
    e_mrv = '0; e_ws = 1'b0; e_rs = 1'b0; e_to = 1'b0; w = -1;
    if (sn_rst) begin
      mp_pend = '0; m_inf = -1; m_last = N - 1; m_live = 1'b0; m_age = 0; m_inf_wr = 1'b0;
      e_saddr = '0; e_swd = '0;
      for (int i = 0; i < N; i++) e_rdata[i] = '0;
    end else begin
      m_live = 1'b1;
      if (m_inf >= 0) begin
        m_age++;
        if (m_inf_wr) begin
          if (m_age >= 2 && sn_srdy) begin mp_pend[m_inf] = 1'b0; m_inf = -1; end
        end else if (sn_rv) begin
          e_mrv[m_inf] = 1'b1; e_rdata[m_inf] = sn_rdat; mp_pend[m_inf] = 1'b0; m_inf = -1;
        end else if (m_age == TO) begin
          e_mrv[m_inf] = 1'b1; e_rdata[m_inf] = '0; e_to = 1'b1; mp_pend[m_inf] = 1'b0; m_inf = -1;
        end
      end else if (mp_pend != '0 && sn_srdy) begin
        for (int k = 1; k <= N; k++)
          if (w < 0 && mp_pend[(m_last + k) % N]) w = (m_last + k) % N;
        m_inf = w; m_inf_wr = mp_wr[w]; m_age = 0; m_last = w;
        e_saddr = mp_addr[w]; e_swd = mp_data[w];
        if (mp_wr[w]) e_ws = 1'b1; else e_rs = 1'b1;
      end
      cap = sn_rdy & (sn_ws | sn_rs);
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          mp_pend[i] = 1'b1;
          mp_addr[i] = sn_addr[32*i +: 32];
          mp_data[i] = sn_wd[32*i +: 32];
          mp_wr[i]   = sn_ws[i];
        end
      end
    end
    e_rdy = m_live ? ~mp_pend : '0;
    for (int i = 0; i < N; i++) e_flat[32*i +: 32] = e_rdata[i];
    chk("ready", m_sb_ready, e_rdy);
    chk("s_wstrobe", s_sb_write_strobe, e_ws);
    chk("s_rstrobe", s_sb_read_strobe, e_rs);
    chk("s_addr", s_sb_address, e_saddr);
    chk("s_wdata", s_sb_write_data, e_swd);
    chk("m_rvalid", m_sb_read_valid, e_mrv);
    chk("m_rdata", m_sb_read_data, e_flat);
    chk("rd_timeout", read_timeout, e_to);
    if (s_sb_write_strobe || s_sb_read_strobe) alog.push_back(s_sb_address);
    sn_rst = reset; sn_rs = m_sb_read_strobe; sn_ws = m_sb_write_strobe;
    sn_addr = m_sb_address; sn_wd = m_sb_write_data; sn_srdy = s_sb_ready;
    sn_rv = s_sb_read_valid; sn_rdat = s_sb_read_data; sn_rdy = e_rdy;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_strobe(input logic rd, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (rd ? s_sb_read_strobe : s_sb_write_strobe) seen = 1'b1;
    end
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data);
    m_sb_address[32*m +: 32] = addr;
    m_sb_write_data[32*m +: 32] = data;
    m_sb_write_strobe[m] = 1'b1;
    tick();
    m_sb_write_strobe[m] = 1'b0;
  endtask

  // dly>0: slave answers on the dly-th edge after the strobe; dly=0: never answers.
  task automatic do_read(input int m, input logic [31:0] addr, input int dly,
                         input logic [31:0] data, output logic seen);
    m_sb_address[32*m +: 32] = addr;
    m_sb_read_strobe[m] = 1'b1;
    tick();
    m_sb_read_strobe[m] = 1'b0;
    wait_strobe(1'b1, seen);
    if (seen && dly > 0) begin
      repeat (dly - 1) tick();
      s_sb_read_data = data; s_sb_read_valid = 1'b1;
      tick();
      s_sb_read_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] alog_at(input int idx);
    return (idx < alog.size()) ? alog[idx] : 32'hFFFF_FFFF;
  endfunction

  initial begin : p_stim
    logic seen;
    int   base, cnt, rv_seen;
    repeat (2) tick();
    chk("rst_ready", m_sb_ready, 4'h0);
    chk("rst_strobes", {s_sb_write_strobe, s_sb_read_strobe}, 2'b00);
    reset = 1'b0;
    tick();
    chk("rst_release_ready", m_sb_ready, 4'hF);

    // single write with two-edge latency to the slave strobe
    do_write(0, 32'h40, 32'hA5A5_0001);
    tick();
    chk("t1_latency", s_sb_write_strobe, 1'b1);
    chk("t1_addr", s_sb_address, 32'h40);
    chk("t1_data", s_sb_write_data, 32'hA5A5_0001);
    chk("t1_busy", m_sb_ready[0], 1'b0);
    repeat (4) tick();
    chk("t1_ready_back", m_sb_ready[0], 1'b1);

    // read with 3-cycle slave latency
    do_read(1, 32'h10, 3, 32'h1234_5678, seen);
    chk("t2_strobe_seen", seen, 1'b1);
    chk("t2_rvalid", m_sb_read_valid, 4'b0010);
    chk("t2_rdata", m_sb_read_data[63:32], 32'h1234_5678);
    chk("t2_m0_quiet", m_sb_read_data[31:0], 32'h0);
    tick();
    chk("t2_rvalid_pulse", m_sb_read_valid, 4'b0000);
    chk("t2_rdata_hold", m_sb_read_data[63:32], 32'h1234_5678);
    repeat (3) tick();
    s_sb_read_data = 32'h0BAD_0BAD; s_sb_read_valid = 1'b1;
    tick();
    s_sb_read_valid = 1'b0;
    chk("t2_stray_rv", m_sb_read_valid, 4'b0000);

    // contention, last_grant=1 -> m0 first
    base = alog.size();
    m_sb_address[31:0] = 32'h300; m_sb_address[63:32] = 32'h310;
    m_sb_write_strobe = 4'b0011;
    tick();
    m_sb_write_strobe = '0;
    repeat (12) tick();
    chk("t3a_first", alog_at(base), 32'h300);
    chk("t3a_second", alog_at(base + 1), 32'h310);
    do_write(0, 32'h320, 32'h1);
    repeat (6) tick();
    // contention, last_grant=0 -> m1 first
    base = alog.size();
    m_sb_address[31:0] = 32'h330; m_sb_address[63:32] = 32'h340;
    m_sb_write_strobe = 4'b0011;
    tick();
    m_sb_write_strobe = '0;
    repeat (12) tick();
    chk("t3b_first", alog_at(base), 32'h340);
    chk("t3b_second", alog_at(base + 1), 32'h330);

    // fairness: all masters keep requesting; last_grant=0 so rotation starts at m1
    base = alog.size();
    for (int i = 0; i < N; i++) m_sb_address[32*i +: 32] = 32'h100 + 32'(4 * i);
    m_sb_write_strobe = '1;
    for (int c = 0; c < 600 && alog.size() < base + 40; c++) begin
      for (int i = 0; i < N; i++) m_sb_write_data[32*i +: 32] = 32'hD000_0000 + 32'(c * 16 + i);
      tick();
    end
    m_sb_write_strobe = '0;
    chk("t4_count", 32'(alog.size() >= base + 40), 32'd1);
    for (int j = 0; j < 40; j++)
      chk($sformatf("t4_order_%0d", j), alog_at(base + j), 32'h100 + 32'(4 * ((1 + j) % N)));
    repeat (10) tick();

    // timeout after a successful read to m2
    do_read(2, 32'h500, 2, 32'hCAFE_0002, seen);
    chk("t5_pre_rdata", m_sb_read_data[95:64], 32'hCAFE_0002);
    repeat (2) tick();
    do_read(2, 32'h504, 0, 32'h0, seen);
    chk("t5_strobe_seen", seen, 1'b1);
    cnt = 0;
    for (int c = 1; c <= 20 && cnt == 0; c++) begin
      tick();
      if (read_timeout) cnt = c;
    end
    chk("t5_timeout_delay", cnt, 8);
    chk("t5_rvalid", m_sb_read_valid, 4'b0100);
    chk("t5_rdata_zero", m_sb_read_data[95:64], 32'h0);
    tick();
    chk("t5_timeout_pulse", read_timeout, 1'b0);
    repeat (3) tick();

    // reset during R_WAIT with m2 also pending (last_grant=2 -> m1 goes first)
    m_sb_address[63:32] = 32'h600; m_sb_address[95:64] = 32'h700;
    m_sb_read_strobe[1] = 1'b1; m_sb_write_strobe[2] = 1'b1;
    tick();
    m_sb_read_strobe = '0; m_sb_write_strobe = '0;
    wait_strobe(1'b1, seen);
    chk("t6_strobe_seen", seen, 1'b1);
    chk("t6_addr", s_sb_address, 32'h600);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_ready", m_sb_ready, 4'h0);
    chk("t6_rst_saddr", s_sb_address, 32'h0);
    chk("t6_rst_rdata", m_sb_read_data, 128'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_ready_after", m_sb_ready, 4'hF);
    rv_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (m_sb_read_valid != '0 || read_timeout || s_sb_write_strobe || s_sb_read_strobe) rv_seen++;
    end
    chk("t6_no_stale", rv_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
